player_hit_ctl: RTL
===================

// Module: player_hit_ctl
// PURPOSE
//  Player-side consumer of enemy missile positions. Once per frame it tests every
//  active enemy missile against the player hitbox and decrements the player's lives.
//  Each hit is followed by an invulnerability/blink window. The block raises game over
//  when no lives remain. It sits beside the player control/draw chain: lives/blink feed
//  the player draw stage, game_over feeds the top-level game FSM.
// PARAMETERS
//  N_EN        4     number of enemy missile inputs (packed buses)
//  PL_W        64    player hitbox width  [px]
//  PL_H        48    player hitbox height [px]
//  LIVES_INIT  3     lives loaded at reset/restart (1..7)
//  INV_FRAMES  90    invulnerability frames after a hit (>=1, <=255)
//  BLINK_DIV   4     blink toggle period in frames (>=1)
// PORTS
//  pclk           in   1        pixel clock; single clock domain
//  rst            in   1        synchronous reset, active high
//  vblnk_in       in   1        vertical blank from timing chain; rising edge = frame tick
//  xpos_player    in   11       player hitbox left x
//  ypos_player    in   11       player hitbox top y
//  en_x_missile   in   11*N_EN  missile i x at [11*i+10:11*i]
//  en_y_missile   in   11*N_EN  missile i y at [11*i+10:11*i]
//  en_missile_on  in   N_EN     missile i in flight; ignored when 0
//  restart        in   1        1-cycle pulse: leave DEAD, reload lives
//  lives          out  3        remaining lives
//  player_on      out  1        player drawn/controllable
//  blink          out  1        1 = suppress player sprite this frame (invuln flicker)
//  hit_pulse      out  1        1-cycle pulse per accepted hit
//  game_over      out  1        level, high in DEAD
// BEHAVIOUR
//  Reset (sync, every pclk edge while rst=1)
//   - state=ALIVE, lives=LIVES_INIT, player_on=1, blink=0, hit_pulse=0, game_over=0
//   - inv_cnt=0, blink_cnt=0, vblnk_d=0
//   - rst dominates all other inputs in any state, including mid-INVULN.
//  Frame tick
//   - tick = vblnk_in & ~vblnk_d, where vblnk_d is vblnk_in registered. One cycle per frame.
//  Collision (combinational, 12-bit arithmetic, no wrap)
//   - hit_i = on[i] & mx>=xp & mx<xp+PL_W & my>=yp & my<yp+PL_H.
//   - any_hit = OR of hit_i. Multiple simultaneous hits count as one.
//  FSM
//   - ALIVE : tick & any_hit -> HIT; else stay.
//   - HIT   : one cycle. hit_pulse=1, lives<=lives-1.
//             If lives==1 -> DEAD; else -> INVULN with inv_cnt=INV_FRAMES and blink_cnt=0.
//   - INVULN: hits ignored. On each tick: inv_cnt--, blink_cnt++.
//             When blink_cnt reaches BLINK_DIV-1, blink toggles and blink_cnt wraps to 0.
//             On the tick where inv_cnt==1 -> ALIVE with blink=0.
//   - DEAD  : player_on=0, game_over=1, blink=0, lives=0; hits and ticks ignored.
//             restart -> ALIVE with lives=LIVES_INIT.
//   - restart outside DEAD is ignored.
//  Latency
//   - Hit sampled on tick cycle T; hit_pulse and lives update are registered at T+1.
//   - game_over rises at T+2.
//  Boundaries
//   - lives never underflows; no decrement in DEAD.
//   - A missile exactly on the right/bottom edge (x = xp+PL_W) is a miss.
//   - A tick coinciding with the HIT cycle is ignored.
//   - vblnk_in held high produces one tick only.
// TESTING
//  1 Missile 0 at (xp+10, yp+10), on=1, one tick -> hit_pulse 1 cycle at T+1;
//    lives 3->2; state INVULN.
//  2 Missile at (xp+PL_W, yp) and at (xp-1, yp) over 5 ticks -> no hit_pulse; lives stays 3.
//  3 Hit, then keep missile overlapping for 90 ticks -> no second hit during INVULN;
//    blink toggles every 4 ticks.
//  4 All N_EN missiles overlapping on one tick -> exactly one hit_pulse; lives-1.
//  5 Three spaced hits -> lives 0; game_over=1 at T+2; player_on=0.
//    restart -> lives=3, game_over=0.
//  6 rst asserted mid-INVULN (inv_cnt=40) -> next cycle ALIVE, lives=3, blink=0.

Source files
------------

// File: rtl/player_hit_ctl_if.sv
// Signal bundle between the game datapath and the player hit controller.
// Missile and player coordinates flow in; lives, draw control and game state flow out.
interface player_hit_ctl_if #(
  parameter int N_EN = 4
);
  logic                 vblnk_in;
  logic [10:0]          xpos_player;
  logic [10:0]          ypos_player;
  logic [11*N_EN-1:0]   en_x_missile;
  logic [11*N_EN-1:0]   en_y_missile;
  logic [N_EN-1:0]      en_missile_on;
  logic                 restart;
  logic [2:0]           lives;
  logic                 player_on;
  logic                 blink;
  logic                 hit_pulse;
  logic                 game_over;
  logic [1:0]           state_dbg;

  modport master (
    output vblnk_in, xpos_player, ypos_player, en_x_missile, en_y_missile,
           en_missile_on, restart,
    input  lives, player_on, blink, hit_pulse, game_over, state_dbg
  );

  modport slave (
    input  vblnk_in, xpos_player, ypos_player, en_x_missile, en_y_missile,
           en_missile_on, restart,
    output lives, player_on, blink, hit_pulse, game_over, state_dbg
  );
endinterface

// File: rtl/player_hit_ctl.sv
// Per-frame missile-vs-player collision test, lives bookkeeping, invulnerability
// blink window and game-over state. state_dbg exposes the FSM state for checkers.
module player_hit_ctl #(
  parameter int N_EN       = 4,
  parameter int PL_W       = 64,
  parameter int PL_H       = 48,
  parameter int LIVES_INIT = 3,
  parameter int INV_FRAMES = 90,
  parameter int BLINK_DIV  = 4
) (
  input logic             pclk,
  input logic             rst,
  player_hit_ctl_if.slave hif
);

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    HIT    = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  lives_q, lives_nxt;
  logic [7:0]  inv_cnt, inv_nxt;
  logic [7:0]  blink_cnt, bcnt_nxt;
  logic        blink_q, blink_nxt;
  logic        hit_q, hit_nxt;
  logic        vblnk_d;
  logic        tick;
  logic        any_hit;
  logic [N_EN-1:0] hit_vec;
  logic [11:0] xp, yp, xp_end, yp_end;

  assign tick = hif.vblnk_in & ~vblnk_d;

  // 12-bit compare so xp+PL_W near the screen edge cannot wrap.
  assign xp     = {1'b0, hif.xpos_player};
  assign yp     = {1'b0, hif.ypos_player};
  assign xp_end = xp + 12'(PL_W);
  assign yp_end = yp + 12'(PL_H);

  for (genvar i = 0; i < N_EN; i++) begin : g_hit
    logic [11:0] mx, my;
    assign mx = {1'b0, hif.en_x_missile[11*i +: 11]};
    assign my = {1'b0, hif.en_y_missile[11*i +: 11]};
    assign hit_vec[i] = hif.en_missile_on[i] & (mx >= xp) & (mx < xp_end)
                        & (my >= yp) & (my < yp_end);
  end

  assign any_hit = |hit_vec;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= ALIVE;
      lives_q   <= 3'(LIVES_INIT);
      inv_cnt   <= '0;
      blink_cnt <= '0;
      blink_q   <= 1'b0;
      hit_q     <= 1'b0;
      vblnk_d   <= 1'b0;
    end else begin
      state     <= state_nxt;
      lives_q   <= lives_nxt;
      inv_cnt   <= inv_nxt;
      blink_cnt <= bcnt_nxt;
      blink_q   <= blink_nxt;
      hit_q     <= hit_nxt;
      vblnk_d   <= hif.vblnk_in;
    end
  end

  // The decrement is taken on the ALIVE->HIT edge so lives and hit_pulse
  // change together; HIT then only decides between INVULN and DEAD.
  always_comb begin
    state_nxt = state;
    lives_nxt = lives_q;
    inv_nxt   = inv_cnt;
    bcnt_nxt  = blink_cnt;
    blink_nxt = blink_q;
    hit_nxt   = 1'b0;
    case (state)
      ALIVE: begin
        if (tick && any_hit && lives_q != 3'd0) begin
          state_nxt = HIT;
          hit_nxt   = 1'b1;
          lives_nxt = lives_q - 3'd1;
        end
      end
      HIT: begin
        if (lives_q == 3'd0) begin
          state_nxt = DEAD;
        end else begin
          state_nxt = INVULN;
          inv_nxt   = 8'(INV_FRAMES);
          bcnt_nxt  = '0;
        end
      end
      INVULN: begin
        if (tick) begin
          if (inv_cnt == 8'd1) begin
            state_nxt = ALIVE;
            inv_nxt   = '0;
            bcnt_nxt  = '0;
            blink_nxt = 1'b0;
          end else begin
            inv_nxt = inv_cnt - 8'd1;
            if (blink_cnt == 8'(BLINK_DIV - 1)) begin
              blink_nxt = ~blink_q;
              bcnt_nxt  = '0;
            end else begin
              bcnt_nxt = blink_cnt + 8'd1;
            end
          end
        end
      end
      DEAD: begin
        lives_nxt = '0;
        blink_nxt = 1'b0;
        if (hif.restart) begin
          state_nxt = ALIVE;
          lives_nxt = 3'(LIVES_INIT);
        end
      end
      default: state_nxt = ALIVE;
    endcase
  end

  assign hif.lives     = lives_q;
  assign hif.player_on = (state != DEAD);
  assign hif.game_over = (state == DEAD);
  assign hif.blink     = blink_q;
  assign hif.hit_pulse = hit_q;
  assign hif.state_dbg = state;

endmodule
